// File: rtl/raybox_pkg.sv
// Shared constants and state encoding for the wall texture V-coordinate stepper.
// Step and accumulator are unsigned fixed point: TEX_BITS integer bits, FRAC_BITS fraction.
package raybox_pkg;

    localparam int HEIGHT_BITS = 10;
    localparam int TEX_BITS    = 6;
    localparam int FRAC_BITS   = 12;
    localparam int SCREEN_H    = 480;
    localparam int POS_BITS    = 10;

    localparam int ACC_BITS  = TEX_BITS + FRAC_BITS;
    localparam int DIV_BITS  = ACC_BITS + 1;
    localparam int MUL_BITS  = 9;
    localparam int MUL_STEPS = 9;
    localparam int MUL_CW    = 4;

    localparam logic [DIV_BITS-1:0] V_ONE = {1'b1, {ACC_BITS{1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIV    = 2'd1,
        MUL    = 2'd2,
        ACTIVE = 2'd3
    } stepper_state_e;

    // Clamp the raw quotient into the step range; a zero-height wall never steps.
    function automatic logic [ACC_BITS-1:0] sat_step(input logic [DIV_BITS-1:0] q,
                                                     input logic zero_h);
        logic [ACC_BITS-1:0] r;
        if (zero_h) begin
            r = '0;
        end else if (q[ACC_BITS]) begin
            r = '1;
        end else begin
            r = q[ACC_BITS-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/wall_tex_stepper_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; start restarts any divide in flight.
module seq_divider #(
    parameter int DW = 19,
    parameter int VW = 10,
    parameter int CW = $clog2(DW + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient
);

    logic [DW-1:0] quo_r;
    logic [VW-1:0] rem_r;
    logic [VW-1:0] div_r;
    logic [CW-1:0] cnt_r;
    logic          busy_r;
    logic          done_r;

    logic [VW:0]   trial_s;
    logic [VW:0]   diff_s;
    logic          ge_s;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        trial_s = {rem_r, quo_r[DW-1]};
        diff_s  = trial_s - {1'b0, div_r};
        ge_s    = (trial_s >= {1'b0, div_r});
    end

    // Iteration registers; dividend bits shift out as quotient bits shift in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quo_r  <= '0;
            rem_r  <= '0;
            div_r  <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            quo_r  <= dividend;
            rem_r  <= '0;
            div_r  <= divisor;
            cnt_r  <= CW'(DW);
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            quo_r <= {quo_r[DW-2:0], ge_s};
            rem_r <= ge_s ? diff_s[VW-1:0] : trial_s[VW-1:0];
            cnt_r <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign quotient = quo_r;

endmodule

// File: rtl/wall_tex_stepper.sv
// Per-line texture V stepper: latches the wall slice, derives step and start offset,
// then walks the accumulator one pixel per pix_valid to address the texture ROM.
module wall_tex_stepper
    import raybox_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   line_start,
    input  logic [HEIGHT_BITS-1:0] wall_height,
    input  logic                   side_in,
    input  logic [TEX_BITS-1:0]    tex_u,
    input  logic                   pix_valid,
    output logic                   ready,
    output logic                   in_wall,
    output logic [TEX_BITS-1:0]    tex_row,
    output logic [TEX_BITS-1:0]    tex_col,
    output logic                   tex_side
);

    localparam logic [HEIGHT_BITS-1:0] SCREEN_HH = HEIGHT_BITS'(SCREEN_H);
    localparam logic [POS_BITS-1:0]    SCREEN_HP = POS_BITS'(SCREEN_H);

    stepper_state_e        state_r;
    stepper_state_e        state_s;

    logic [HEIGHT_BITS-1:0] h_r;
    logic                   side_r;
    logic [TEX_BITS-1:0]    col_r;
    logic [ACC_BITS-1:0]    step_r;
    logic [ACC_BITS-1:0]    acc_r;
    logic [POS_BITS-1:0]    y_r;
    logic [MUL_BITS-1:0]    skip_r;
    logic [MUL_CW-1:0]      mul_cnt_r;
    logic                   ready_r;
    logic                   in_wall_r;
    logic [TEX_BITS-1:0]    tex_row_r;

    logic [POS_BITS-1:0]    top_s;
    logic [POS_BITS-1:0]    bot_s;
    logic [MUL_BITS-1:0]    skip_s;
    logic                   hit_s;
    logic                   mul_last_s;
    logic [ACC_BITS-1:0]    acc_mul_s;
    logic                   div_busy_s;
    logic                   div_done_s;
    logic [DIV_BITS-1:0]    div_q_s;

    seq_divider #(
        .DW(DIV_BITS),
        .VW(HEIGHT_BITS)
    ) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (line_start),
        .dividend (V_ONE),
        .divisor  (wall_height),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quotient (div_q_s)
    );

    // Wall span on screen, start-row skip for tall walls, and the MSB-first shift-add step.
    always_comb begin
        if (h_r >= SCREEN_HH) begin
            top_s = '0;
            bot_s = SCREEN_HP;
        end else begin
            top_s = POS_BITS'((SCREEN_HH - h_r) >> 1);
            bot_s = top_s + POS_BITS'(h_r);
        end
        if (h_r > SCREEN_HH) begin
            skip_s = MUL_BITS'((h_r - SCREEN_HH) >> 1);
        end else begin
            skip_s = '0;
        end
        hit_s      = (y_r >= top_s) && (y_r < bot_s) && (h_r != '0);
        mul_last_s = (mul_cnt_r == MUL_CW'(1));
        acc_mul_s  = {acc_r[ACC_BITS-2:0], 1'b0} + (skip_r[MUL_BITS-1] ? step_r : '0);
    end

    // Next-state logic; a new line always restarts the computation.
    always_comb begin
        state_s = state_r;
        if (line_start) begin
            state_s = DIV;
        end else begin
            case (state_r)
                IDLE:    state_s = IDLE;
                DIV:     if (div_done_s && !div_busy_s) state_s = MUL; else state_s = DIV;
                MUL:     if (mul_last_s) state_s = ACTIVE; else state_s = MUL;
                ACTIVE:  state_s = ACTIVE;
                default: state_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Line latch, step/offset capture and per-pixel accumulator walk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_r       <= '0;
            side_r    <= 1'b0;
            col_r     <= '0;
            step_r    <= '0;
            acc_r     <= '0;
            y_r       <= '0;
            skip_r    <= '0;
            mul_cnt_r <= '0;
            ready_r   <= 1'b0;
            in_wall_r <= 1'b0;
            tex_row_r <= '0;
        end else begin
            ready_r <= (state_s == ACTIVE);
            if (line_start) begin
                h_r       <= wall_height;
                side_r    <= side_in;
                col_r     <= tex_u;
                y_r       <= '0;
                acc_r     <= '0;
                in_wall_r <= 1'b0;
            end else begin
                case (state_r)
                    DIV: begin
                        if (state_s == MUL) begin
                            step_r    <= sat_step(div_q_s, h_r == '0);
                            skip_r    <= skip_s;
                            mul_cnt_r <= MUL_CW'(MUL_STEPS);
                        end
                    end
                    MUL: begin
                        acc_r     <= acc_mul_s;
                        skip_r    <= skip_r << 1;
                        mul_cnt_r <= mul_cnt_r - MUL_CW'(1);
                    end
                    ACTIVE: begin
                        if (pix_valid) begin
                            in_wall_r <= hit_s;
                            tex_row_r <= acc_r[ACC_BITS-1 -: TEX_BITS];
                            if (hit_s) begin
                                acc_r <= acc_r + step_r;
                            end
                            if (y_r != SCREEN_HP) begin
                                y_r <= y_r + POS_BITS'(1);
                            end
                        end
                    end
                    default: begin
                        if (pix_valid) begin
                            in_wall_r <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign ready    = ready_r;
    assign in_wall  = in_wall_r;
    assign tex_row  = tex_row_r;
    assign tex_col  = col_r;
    assign tex_side = side_r;

endmodule
